// File: rtl/bcd2bin_seq.sv
// Sequential two-digit signed BCD to 8-bit two's-complement converter (reverse double-dabble).
// Optional invalid-digit checking is enabled by defining BCD2BIN_ERRCHK_EN.
module bcd2bin_seq (
  input  logic       clk,
  input  logic       ar,
  input  logic       start,
  input  logic       sign,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       busy,
  output logic       done,
  output logic [7:0] bin,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX} state_t;

  state_t      state_q, state_d;
  logic [14:0] work_q, work_d;   // {bcd[7:0], acc[6:0]}
  logic [2:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic [7:0]  bin_q, bin_d;

  logic [14:0] shifted;
  logic [3:0]  hi_fix, lo_fix;
  logic [7:0]  mag8, signed_res;

  // Nibble corrections are independent 4-bit subtracts with no carry between them.
  always_comb begin
    shifted = work_q >> 1;
    hi_fix  = shifted[14:11];
    lo_fix  = shifted[10:7];
    if (hi_fix >= 4'd8) hi_fix = hi_fix - 4'd3;
    if (lo_fix >= 4'd8) lo_fix = lo_fix - 4'd3;
    mag8       = {1'b0, work_q[6:0]};
    signed_res = sign_q ? (~mag8 + 8'd1) : mag8;
  end

`ifdef BCD2BIN_ERRCHK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    done_d  = 1'b0;
    bin_d   = bin_q;
`ifdef BCD2BIN_ERRCHK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {tens, ones, 7'd0};
          sign_d  = sign;
          cnt_d   = 3'd0;
          state_d = SHIFT;
`ifdef BCD2BIN_ERRCHK_EN
          bad_d   = (tens > 4'd9) || (ones > 4'd9);
`endif
        end
      end
      SHIFT: begin
        work_d = {hi_fix, lo_fix, shifted[6:0]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd6) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        bin_d   = signed_res;
        state_d = IDLE;
`ifdef BCD2BIN_ERRCHK_EN
        err_d   = bad_q;
        if (bad_q) bin_d = 8'h00;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef BCD2BIN_ERRCHK_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_ERRCHK_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign bin  = bin_q;
`ifdef BCD2BIN_ERRCHK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized self-checking bench for bcd2bin_seq against a decimal arithmetic reference.
module tb_bcd2bin_seq;
  logic       clk = 1'b0;
  logic       ar, start, sign;
  logic [3:0] tens, ones;
  logic       busy, done, err;
  logic [7:0] bin;

  int n_tests = 0;
  int n_fail  = 0;
  int dbl_done = 0;
  logic done_prev = 1'b0;

  bcd2bin_seq dut (
    .clk(clk), .ar(ar), .start(start), .sign(sign), .tens(tens), .ones(ones),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_prev && done) dbl_done++;
    done_prev <= done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic s, input int t, input int o);
    int v;
    v = 10 * t + o;
    if (s) v = -v;
    return 8'(v);
  endfunction

  // Present a start for one accepting edge; returns at the negedge after it.
  task automatic issue(input logic s, input logic [3:0] t, input logic [3:0] o);
    start = 1'b1; sign = s; tens = t; ones = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scrambles the operand inputs while waiting, so input stability is exercised too.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      sign = 1'($urandom); tens = 4'($urandom); ones = 4'($urandom);
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
  endtask

  initial begin
    int lat, ndone;
    int vals[$];
    ar = 1'b1; start = 1'b0; sign = 1'b0; tens = 4'd0; ones = 4'd0;
    repeat (2) @(negedge clk);
    ar = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin",  bin,  0);
    chk("rst_err",  err,  0);

    issue(1'b0, 4'd4, 4'd7);
    chk("busy_after_accept", busy, 1);
    wait_done(lat);
    chk("p47_lat", lat, 8);
    chk("p47_bin", bin, 32'h2F);
    chk("p47_err", err, 0);
    chk("p47_busy", busy, 0);

    issue(1'b1, 4'd9, 4'd9); wait_done(lat);
    chk("m99_bin", bin, 32'h9D);
    chk("m99_lat", lat, 8);
    issue(1'b1, 4'd0, 4'd0); wait_done(lat);
    chk("m0_bin", bin, 32'h00);

    // starts while busy must be ignored; start in the done cycle is accepted
    issue(1'b0, 4'd1, 4'd2);
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      start = (i == 3 || i == 7); sign = 1'b0; tens = 4'd5; ones = 4'd5;
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_done_now", done, 1);
    chk("ign_bin", bin, 32'h0C);
    issue(1'b0, 4'd5, 4'd5);
    wait_done(lat);
    chk("b2b_lat", lat, 8);
    chk("b2b_bin", bin, 32'h37);

    // reset mid-conversion
    issue(1'b1, 4'd3, 4'd5);
    repeat (3) @(negedge clk);
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
    chk("arst_busy", busy, 0);
    chk("arst_bin", bin, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("arst_nodone", ndone, 0);
    issue(1'b0, 4'd0, 4'd1); wait_done(lat);
    chk("p1_bin", bin, 32'h01);
    chk("p1_lat", lat, 8);

`ifdef BCD2BIN_ERRCHK_EN
    issue(1'b0, 4'hA, 4'd3); wait_done(lat);
    chk("bad_lat", lat, 8);
    chk("bad_err", err, 1);
    chk("bad_bin", bin, 0);
    issue(1'b0, 4'd0, 4'd9); wait_done(lat);
    chk("p9_err", err, 0);
    chk("p9_bin", bin, 32'h09);
`endif

    // full sweep of -99..+99 in shuffled order with random idle gaps
    for (int v = -99; v <= 99; v++) vals.push_back(v);
    for (int i = vals.size() - 1; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    foreach (vals[k]) begin
      int v, a;
      logic s;
      logic [7:0] held;
      v = vals[k];
      s = (v < 0) ? 1'b1 : (v == 0 ? 1'($urandom) : 1'b0);
      a = (v < 0) ? -v : v;
      held = bin;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      chk("hold_bin", bin, held);
      issue(s, 4'(a / 10), 4'(a % 10));
      wait_done(lat);
      chk($sformatf("sweep_lat_%0d", v), lat, 8);
      chk($sformatf("sweep_bin_%0d", v), bin, model(s, a / 10, a % 10));
      chk($sformatf("sweep_err_%0d", v), err, 0);
    end

    @(negedge clk);
    chk("done_single_cycle", dbl_done, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
